// File: rtl/chrono_pkg.sv
// -----------------------------------------------------------------------------
// chrono_pkg
//   Shared definitions for the chronometer core:
//     - state_t  : top-level controller states (IDLE / RUN / PAUSE / DONE)
//     - BCD_W    : width of one BCD digit
//     - calc_div : prescaler division ratio from clock and tick frequencies
// -----------------------------------------------------------------------------
package chrono_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of fabric clock cycles per counter tick.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
//   One BCD digit of the chronometer value. Counts up or down by one when
//   cin is high and ripples a carry (up) or borrow (down) to the next digit.
//
//   Ports:
//     clk       fabric clock
//     rst       asynchronous reset, active-low
//     clear     synchronous clear to 0 (highest priority)
//     load      synchronous load of load_val (A-F are loaded as 9)
//     load_val  digit value to load
//     down      0 = count up, 1 = count down
//     cin       count enable / carry-or-borrow in from the lower digit
//     q         current digit value
//     cout      carry (up, q==9) or borrow (down, q==0) out to the next digit
// -----------------------------------------------------------------------------
module bcd_digit
    import chrono_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             down,
    input  logic             cin,
    output logic [BCD_W-1:0] q,
    output logic             cout
);

    logic [BCD_W-1:0] load_fix;

    // Non-decimal digits saturate to 9 so the counter never holds an illegal code.
    assign load_fix = (load_val > 4'd9) ? 4'd9 : load_val;

    // The digit only passes the event on when it wraps.
    assign cout = cin & (down ? (q == 4'd0) : (q == 4'd9));

    // NOTE: every sequential register is written with <= so all flops update
    // from the same pre-edge values; = here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_fix;
        end else if (cin) begin
            if (down) begin
                q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
            end else begin
                q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/chrono_lap_timer.sv
// -----------------------------------------------------------------------------
// chrono_lap_timer
//   Single-clock chronometer core: tick prescaler, DIGITS-digit BCD up/down
//   counter, lap capture and countdown done flag. All timing is derived from
//   a tick-enable on the fabric clock; there are no generated clocks.
//
//   Parameters:
//     CLK_FPGA   input clock frequency in Hz
//     TICK_HZ    counter increment rate in Hz (CLK_FPGA/TICK_HZ must be >= 2)
//     DIGITS     number of BCD digits (value width = 4*DIGITS)
//
//   Ports:
//     clk        fabric clock
//     rst        asynchronous reset, active-low
//     start      start/resume request (rising edge)
//     stop       pause request (rising edge)
//     restart    clear/reload request (rising edge)
//     lap        lap capture request (rising edge)
//     mode_down  0 = count up, 1 = count down; latched when leaving IDLE
//     preload    countdown start value (BCD)
//     value      live BCD count
//     lap_value  last captured count
//     lap_valid  one-cycle pulse when lap_value updates
//     running    high in RUN
//     done       high in DONE (countdown reached 0)
//     overflow   sticky, set when the up-count wraps all-9s to 0
// -----------------------------------------------------------------------------
module chrono_lap_timer
    import chrono_pkg::*;
#(
    parameter int CLK_FPGA = 100000000,
    parameter int TICK_HZ  = 100,
    parameter int DIGITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    restart,
    input  logic                    lap,
    input  logic                    mode_down,
    input  logic [DIGITS*BCD_W-1:0] preload,
    output logic [DIGITS*BCD_W-1:0] value,
    output logic [DIGITS*BCD_W-1:0] lap_value,
    output logic                    lap_valid,
    output logic                    running,
    output logic                    done,
    output logic                    overflow
);

    localparam int W   = DIGITS * BCD_W;
    localparam int DIV = calc_div(CLK_FPGA, TICK_HZ);
    localparam int PW  = $clog2(DIV);

    // -------------------------------------------------------------------------
    // Request edge detection: one event per rising edge of each button input.
    // -------------------------------------------------------------------------
    logic start_q, stop_q, restart_q, lap_q;
    logic start_ev, stop_ev, restart_ev, lap_ev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            restart_q <= 1'b0;
            lap_q     <= 1'b0;
        end else begin
            start_q   <= start;
            stop_q    <= stop;
            restart_q <= restart;
            lap_q     <= lap;
        end
    end

    assign start_ev   = start   & ~start_q;
    assign stop_ev    = stop    & ~stop_q;
    assign restart_ev = restart & ~restart_q;
    assign lap_ev     = lap     & ~lap_q;

    // -------------------------------------------------------------------------
    // State register, prescaler and mode latch
    // -------------------------------------------------------------------------
    state_t        state, state_d;
    logic [PW-1:0] presc;
    logic          tick;
    logic          mode_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // The prescaler only advances in RUN, so a pause resumes mid-period.
    assign tick = (state == ST_RUN) && (presc == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (restart_ev || state == ST_IDLE || state == ST_DONE) begin
            presc <= '0;
        end else if (state == ST_RUN) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    // Direction follows mode_down while idle and is frozen from the start edge on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 1'b0;
        end else if (state == ST_IDLE) begin
            mode_q <= mode_down;
        end
    end

    // -------------------------------------------------------------------------
    // BCD digit chain
    // -------------------------------------------------------------------------
    logic [DIGITS:0] carry;
    logic            value_zero;
    logic            value_one;
    logic            reload;
    logic            dig_clear;
    logic            dig_load;

    assign value_zero = (value == '0);
    assign value_one  = (value == W'(1));

    // Countdown never borrows below zero; reaching zero hands over to DONE.
    assign carry[0] = tick & ~restart_ev & ~(mode_q & value_zero);

    // IDLE tracks the start value every cycle; restart reloads from any state.
    assign reload    = (state == ST_IDLE) | restart_ev;
    assign dig_clear = reload ? ~mode_down : (state == ST_DONE);
    assign dig_load  = reload & mode_down;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .clear    (dig_clear),
            .load     (dig_load),
            .load_val (preload[k*BCD_W +: BCD_W]),
            .down     (mode_q),
            .cin      (carry[k]),
            .q        (value[k*BCD_W +: BCD_W]),
            .cout     (carry[k+1])
        );
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: restart > countdown completion > stop > start.
    // -------------------------------------------------------------------------
    logic done_cond;

    // Countdown completes when a tick takes the value from 1 to 0, or when the
    // run began at zero (no tick needed).
    assign done_cond = mode_q & (value_zero | (tick & value_one));

    // NOTE: state_d gets a default before the case so every path assigns it;
    // otherwise the tool infers a latch to hold the old value.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (!restart_ev && start_ev) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (restart_ev) begin
                    state_d = ST_IDLE;
                end else if (done_cond) begin
                    state_d = ST_DONE;
                end else if (stop_ev) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (restart_ev) begin
                    state_d = ST_IDLE;
                end else if (start_ev) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (restart_ev) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: status flags registered alongside the state so they match it.
    // -------------------------------------------------------------------------
    logic running_d, done_d;

    always_comb begin
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            running <= running_d;
            done    <= done_d;
        end
    end

    // Overflow is sticky until restart; only the up-count can wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (restart_ev) begin
            overflow <= 1'b0;
        end else if (carry[DIGITS] && !mode_q) begin
            overflow <= 1'b1;
        end
    end

    // Lap captures the value present before any coincident tick lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_value <= '0;
            lap_valid <= 1'b0;
        end else if (restart_ev) begin
            lap_value <= '0;
            lap_valid <= 1'b0;
        end else if (lap_ev && (state == ST_RUN || state == ST_PAUSE)) begin
            lap_value <= value;
            lap_valid <= 1'b1;
        end else begin
            lap_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chrono_lap_timer.sv
// -----------------------------------------------------------------------------
// tb_chrono_lap_timer
//   Self-checking bench for chrono_lap_timer (CLK_FPGA=20, TICK_HZ=2 -> DIV=10,
//   DIGITS=2). A behavioural model keeps the count as a plain integer and the
//   controller as a small set of named phases; BCD is produced only when
//   comparing against the DUT.
// -----------------------------------------------------------------------------
module tb_chrono_lap_timer;

    localparam int CLK_FPGA = 20;
    localparam int TICK_HZ  = 2;
    localparam int DIGITS   = 2;
    localparam int W        = 4 * DIGITS;
    localparam int DIV      = CLK_FPGA / TICK_HZ;
    localparam int MAXV     = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0, stop = 1'b0, restart = 1'b0, lap = 1'b0;
    logic         mode_down = 1'b0;
    logic [W-1:0] preload = '0;
    logic [W-1:0] value, lap_value;
    logic         lap_valid, running, done, overflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    chrono_lap_timer #(
        .CLK_FPGA (CLK_FPGA),
        .TICK_HZ  (TICK_HZ),
        .DIGITS   (DIGITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .restart   (restart),
        .lap       (lap),
        .mode_down (mode_down),
        .preload   (preload),
        .value     (value),
        .lap_value (lap_value),
        .lap_valid (lap_valid),
        .running   (running),
        .done      (done),
        .overflow  (overflow)
    );

    // ------------------------------------------------------------------ model
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mphase_e;

    mphase_e m_st;
    int      m_val, m_lap, m_pres;
    bit      m_lapv, m_ovf, m_down;
    bit      p_start, p_stop, p_restart, p_lap;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_preload(input logic [W-1:0] pl);
        int r, p, d;
        r = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(pl[i*4 +: 4]);
            if (d > 9) d = 9;
            r += d * p;
            p *= 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_val = 0; m_lap = 0; m_pres = 0;
        m_lapv = 0; m_ovf = 0; m_down = 0;
        p_start = 0; p_stop = 0; p_restart = 0; p_lap = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit s_ev, t_ev, r_ev, l_ev, tk;
        int reload;
        s_ev = start && !p_start;
        t_ev = stop && !p_stop;
        r_ev = restart && !p_restart;
        l_ev = lap && !p_lap;
        p_start = start; p_stop = stop; p_restart = restart; p_lap = lap;
        reload = mode_down ? from_preload(preload) : 0;
        tk = (m_st == M_RUN) && (m_pres == DIV - 1);

        m_lapv = 0;
        if (r_ev) begin
            m_lap = 0;
            m_ovf = 0;
        end else if (l_ev && (m_st == M_RUN || m_st == M_PAUSE)) begin
            m_lap  = m_val;
            m_lapv = 1;
        end

        case (m_st)
            M_IDLE: begin
                m_val  = reload;
                m_pres = 0;
                m_down = mode_down;
                if (!r_ev && s_ev) m_st = M_RUN;
            end
            M_RUN: begin
                if (r_ev) begin
                    m_st = M_IDLE; m_val = reload; m_pres = 0;
                end else begin
                    m_pres = tk ? 0 : m_pres + 1;
                    if (tk) begin
                        if (m_down) begin
                            if (m_val > 0) m_val--;
                        end else if (m_val == MAXV - 1) begin
                            m_val = 0;
                            m_ovf = 1;
                        end else begin
                            m_val++;
                        end
                    end
                    if (m_down && m_val == 0) m_st = M_DONE;
                    else if (t_ev) m_st = M_PAUSE;
                end
            end
            M_PAUSE: begin
                if (r_ev) begin
                    m_st = M_IDLE; m_val = reload; m_pres = 0;
                end else if (s_ev) begin
                    m_st = M_RUN;
                end
            end
            M_DONE: begin
                m_val  = 0;
                m_pres = 0;
                if (r_ev) begin
                    m_st = M_IDLE; m_val = reload;
                end
            end
            default: m_st = M_IDLE;
        endcase
    endtask

    // One clock: model first, then DUT edge, then sample 1 ns later.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1; step(); restart = 1'b0; step();
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({value, lap_value, lap_valid, running, done, overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {value, lap_value, lap_valid, running, done, overflow});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_up_run();
        mode_down = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        repeat (250) step();
        vectors++;
        if (value !== to_bcd(m_val) || value < 8'h24 || value > 8'h25) begin
            miscompares++;
            $display("FAIL up_run_value got=%h exp=%h", value, to_bcd(m_val));
        end
        vectors++;
        if (running !== 1'b1) begin
            miscompares++;
            $display("FAIL up_run_running got=%b exp=1", running);
        end
        // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
        rst = 1'b0;
        #1;
        vectors++;
        if ({value, lap_value, lap_valid, running, done, overflow} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=0",
                     {value, lap_value, lap_valid, running, done, overflow});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_overflow();
        int guard;
        start = 1'b1; step(); start = 1'b0;
        guard = 0;
        while (m_val != 98 && guard < 2000) begin
            step();
            guard++;
        end
        vectors++;
        if (value !== 8'h98) begin
            miscompares++;
            $display("FAIL ovf_reach98 got=%h exp=98 (cycles=%0d)", value, guard);
        end
        repeat (20) step();
        vectors++;
        if (value !== 8'h00 || overflow !== 1'b1 || value !== to_bcd(m_val)) begin
            miscompares++;
            $display("FAIL ovf_wrap got=%h/%b exp=00/1", value, overflow);
        end
        pulse_restart();
        vectors++;
        if (overflow !== 1'b0 || running !== 1'b0 || value !== 8'h00) begin
            miscompares++;
            $display("FAIL ovf_restart got=%b/%b/%h exp=0/0/00", overflow, running, value);
        end
    endtask

    task automatic test_pause();
        start = 1'b1; step(); start = 1'b0;
        repeat (54) step();
        stop = 1'b1; step(); stop = 1'b0;
        vectors++;
        if (value !== 8'h05 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL pause_entry got=%h/%b exp=05/0", value, running);
        end
        repeat (100) step();
        vectors++;
        if (value !== 8'h05 || value !== to_bcd(m_val)) begin
            miscompares++;
            $display("FAIL pause_hold got=%h exp=05", value);
        end
        start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        vectors++;
        if (value !== 8'h05 || running !== 1'b1) begin
            miscompares++;
            $display("FAIL resume_early got=%h/%b exp=05/1", value, running);
        end
        step();
        vectors++;
        if (value !== 8'h06) begin
            miscompares++;
            $display("FAIL resume_remaining got=%h exp=06", value);
        end
    endtask

    task automatic test_countdown();
        logic [W-1:0] exp_seq [3];
        exp_seq[0] = 8'h02; exp_seq[1] = 8'h01; exp_seq[2] = 8'h00;
        mode_down = 1'b1;
        preload   = 8'h03;
        pulse_restart();
        vectors++;
        if (value !== 8'h03) begin
            miscompares++;
            $display("FAIL cd_load got=%h exp=03", value);
        end
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (10) step();
            vectors++;
            if (value !== exp_seq[i] || value !== to_bcd(m_val)) begin
                miscompares++;
                $display("FAIL cd_step%0d got=%h exp=%h", i, value, exp_seq[i]);
            end
        end
        vectors++;
        if (done !== 1'b1 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL cd_done got=%b/%b exp=1/0", done, running);
        end
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        vectors++;
        if (done !== 1'b1 || running !== 1'b0 || value !== 8'h00) begin
            miscompares++;
            $display("FAIL cd_start_ignored got=%b/%b/%h exp=1/0/00", done, running, value);
        end
        pulse_restart();
        vectors++;
        if (value !== 8'h03 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL cd_restart got=%h/%b exp=03/0", value, done);
        end
        // Zero preload finishes without any tick.
        preload = 8'h00;
        step();
        start = 1'b1; step(); start = 1'b0;
        step();
        vectors++;
        if (done !== 1'b1 || value !== 8'h00) begin
            miscompares++;
            $display("FAIL cd_zero_preload got=%b/%h exp=1/00", done, value);
        end
        mode_down = 1'b0;
        pulse_restart();
    endtask

    task automatic test_lap();
        start = 1'b1; step(); start = 1'b0;
        repeat (120) step();
        lap = 1'b1; step();
        vectors++;
        if (lap_valid !== 1'b1 || lap_value !== 8'h12) begin
            miscompares++;
            $display("FAIL lap_capture got=%b/%h exp=1/12", lap_valid, lap_value);
        end
        step();
        vectors++;
        if (lap_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lap_one_cycle got=%b exp=0", lap_valid);
        end
        lap = 1'b0;
        repeat (20) step();
        vectors++;
        if (value !== to_bcd(m_val) || value === 8'h12 || lap_value !== 8'h12) begin
            miscompares++;
            $display("FAIL lap_continue got=%h/%h exp=%h/12", value, lap_value, to_bcd(m_val));
        end
        pulse_restart();
        lap = 1'b1; step(); lap = 1'b0;
        vectors++;
        if (lap_valid !== 1'b0 || lap_value !== 8'h00) begin
            miscompares++;
            $display("FAIL lap_idle got=%b/%h exp=0/00", lap_valid, lap_value);
        end
    endtask

    task automatic test_priority();
        logic [W-1:0] frozen;
        start = 1'b1; step(); start = 1'b0;
        repeat (15) step();
        restart = 1'b1; stop = 1'b1; start = 1'b1; step();
        restart = 1'b0; stop = 1'b0; start = 1'b0; step();
        vectors++;
        if (running !== 1'b0 || value !== 8'h00) begin
            miscompares++;
            $display("FAIL prio_restart got=%b/%h exp=0/00", running, value);
        end
        start = 1'b1; step(); start = 1'b0;
        repeat (25) step();
        stop = 1'b1; start = 1'b1; step();
        stop = 1'b0; start = 1'b0;
        frozen = value;
        repeat (20) step();
        vectors++;
        if (running !== 1'b0 || value !== frozen || value !== to_bcd(m_val)) begin
            miscompares++;
            $display("FAIL prio_stop_over_start got=%b/%h exp=0/%h", running, value, frozen);
        end
        start = 1'b1;
        step();
        vectors++;
        if (running !== 1'b1) begin
            miscompares++;
            $display("FAIL held_start_resume got=%b exp=1", running);
        end
        repeat (24) step();
        stop = 1'b1; step(); stop = 1'b0;
        repeat (24) step();
        vectors++;
        if (running !== 1'b0) begin
            miscompares++;
            $display("FAIL held_start_single got=%b exp=0", running);
        end
        start = 1'b0;
        pulse_restart();
    endtask

    task automatic test_random();
        logic [2*W+3:0] got, exp;
        for (int n = 0; n < 3000; n++) begin
            start   = ($urandom_range(0, 15) == 0);
            stop    = ($urandom_range(0, 25) == 0);
            restart = ($urandom_range(0, 90) == 0);
            lap     = ($urandom_range(0, 8) == 0);
            if ($urandom_range(0, 150) == 0) mode_down = ~mode_down;
            if ($urandom_range(0, 80) == 0)  preload   = W'($urandom);
            step();
            got = {value, lap_value, lap_valid, running, done, overflow};
            exp = {to_bcd(m_val), to_bcd(m_lap), m_lapv,
                   (m_st == M_RUN), (m_st == M_DONE), m_ovf};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random_cycle%0d got=%h exp=%h", n, got, exp);
            end
        end
        start = 1'b0; stop = 1'b0; restart = 1'b0; lap = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_run();
        test_overflow();
        test_pause();
        test_countdown();
        test_lap();
        test_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/chrono_lap_timer.md
Name: chrono_lap_timer

Overview:
Parametrised successor chronometer core. It has an internal tick prescaler and an N-digit BCD counter with up and down (countdown) modes. It also provides lap capture and a done flag.
It replaces the chained clock-divider plus control pair: everything runs on the single fabric clock, using a tick-enable instead of derived clocks.
It sits between the debounced button pulses and the 7-segment display driver.

Parameters:
CLK_FPGA, 100000000, input clock frequency in Hz
TICK_HZ, 100, counter increment rate in Hz; DIV = CLK_FPGA/TICK_HZ, must be >= 2
DIGITS, 4, number of BCD digits; value width W = 4*DIGITS

Ports:
clk  input  1  fabric clock
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  start/resume request, synchronous, sampled on rising edge of signal
stop  input  1  pause request, edge-detected
restart  input  1  clear/reload request, edge-detected
lap  input  1  lap capture request, edge-detected
mode_down  input  1  0 = count up, 1 = count down; sampled only in IDLE
preload  input  W  countdown start value (BCD), sampled on restart and in IDLE
value  output  W  live BCD count
lap_value  output  W  last captured count
lap_valid  output  1  one-cycle pulse when lap_value updates
running  output  1  high in RUN
done  output  1  high in DONE (countdown reached 0)
overflow  output  1  sticky; set when up-count wraps all-9s to 0

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, value=0, lap_value=0, lap_valid=0, running=0, done=0, overflow=0.
  - Prescaler=0; edge-detect registers=0.
- Edge detection:
  - Each of start/stop/restart/lap is registered once.
  - The request event is input & ~prev.
  - Events act one cycle after the input rises.
  - Held levels produce one event only.
- Prescaler:
  - Counts 0..DIV-1 only in RUN. tick=1 in the cycle it equals DIV-1, then it wraps to 0.
  - Holds its value in PAUSE; cleared in IDLE/DONE and on restart.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE: value = mode_down ? preload : 0 each cycle. start -> RUN (mode latched).
  - RUN: on tick, value updates. stop -> PAUSE. restart -> IDLE.
    - Down mode: when value becomes 0 on a tick -> DONE.
  - PAUSE: value and prescaler frozen. start -> RUN. restart -> IDLE.
  - DONE: value=0, done=1. restart -> IDLE. start/stop ignored.
- Simultaneous events, priority: restart > stop > start. lap is independent and evaluated in the same cycle.
- Up count:
  - BCD ripple; digit k increments when all lower digits are 9 and tick=1.
  - All-9s + tick -> all-0 and overflow<=1.
  - overflow is cleared only by restart or reset.
- Down count:
  - BCD borrow; digit 0 with borrow -> 9.
  - Start in down mode with preload=0 -> DONE on the next cycle, with no tick needed.
- Lap: in RUN or PAUSE, lap event -> lap_value <= value (pre-tick value if tick coincides), lap_valid=1 for one cycle. Ignored in IDLE/DONE.
- restart also clears lap_value to 0.
- Non-BCD preload digits (A-F) are treated as 9 on load.
- running = (state==RUN), registered.

Decomposition:
- Package chrono_pkg holds:
  - the state enum (IDLE/RUN/PAUSE/DONE)
  - the BCD digit width constant (4)
  - a function computing DIV from CLK_FPGA/TICK_HZ
- One sub-module, bcd_digit: a single-digit up/down counter with carry/borrow in/out, load and clear. It is instantiated DIGITS times via generate.
- The prescaler, edge detect and FSM stay in the top.

Test Plan (CLK_FPGA=20, TICK_HZ=2 -> DIV=10, DIGITS=2 unless noted):
1. Reset, then start pulse, run 250 cycles -> value=8'h25 ±1 tick, running=1. Assert rst=0 mid-run -> all outputs 0 within the same cycle.
2. Up count from 8'h98 (run to it), then 20 more cycles -> value=8'h00, overflow=1. Then restart -> overflow=0, state IDLE.
3. Start, stop after 55 cycles (value=8'h05), wait 100 cycles -> value stays 8'h05. Start -> next increment after the remaining 5 prescaler cycles, not 10.
4. mode_down=1, preload=8'h03, start -> value 02, 01, 00 at 10-cycle intervals. done=1 and running=0 after 00; start ignored. Restart -> value=8'h03.
5. Lap pulse at value=8'h12 in RUN -> lap_value=8'h12, lap_valid high exactly 1 cycle. Counting continues. Lap in IDLE -> no pulse.
6. restart, stop, start asserted together in RUN -> IDLE. stop+start together in RUN -> PAUSE. start held high 50 cycles in PAUSE -> single resume.
